// File: rtl/atcaxi2tluh500_idx_alloc.sv
// Lowest-free index allocator with busy bitmap, count and outstanding limit.
// Define ATCAXI2TLUH500_IDX_ALLOC_CHECK_EN for the err_free port and assertions.
module atcaxi2tluh500_idx_alloc #(
    parameter  int N     = 8,
    parameter  int LIMIT = N,
    localparam int W     = $clog2(N)
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         clr,
    output logic         alloc_valid,
    input  logic         alloc_ready,
    output logic [W-1:0] alloc_idx,
    output logic [N-1:0] alloc_onehot,
    input  logic         free_valid,
    input  logic [W-1:0] free_idx,
    output logic [N-1:0] busy_vec,
    output logic [W:0]   busy_cnt,
    output logic         empty,
`ifdef ATCAXI2TLUH500_IDX_ALLOC_CHECK_EN
    output logic         full,
    output logic         err_free
`else
    output logic         full
`endif
);

    localparam logic [W:0] LIM_C = (W+1)'(LIMIT);

    logic [N-1:0] r_busy;
    logic [W:0]   r_cnt;

    logic         w_any_free;
    logic [W-1:0] w_low;
    logic         w_cnt_ok;
    logic         w_hs;
    logic [N-1:0] w_hs_vec;
    logic [N-1:0] w_free_vec;
    logic [N-1:0] w_free_eff_vec;
    logic         w_free_eff;
    logic [W:0]   w_cnt_inc;
    logic [W:0]   w_cnt_dec;

    // Scan downward so the last hit is the lowest free entry.
    always_comb begin
        w_any_free = 1'b0;
        w_low      = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_any_free = 1'b1;
                w_low      = W'(i);
            end
        end
    end

    assign w_cnt_ok    = (r_cnt < LIM_C);
    assign alloc_valid = w_any_free & w_cnt_ok;
    assign alloc_idx   = w_low;

    always_comb begin
        alloc_onehot = '0;
        for (int i = 0; i < N; i++) begin
            alloc_onehot[i] = alloc_valid && (w_low == W'(i));
        end
    end

    assign w_hs     = alloc_valid & alloc_ready;
    assign w_hs_vec = alloc_onehot & {N{w_hs}};

    // Indices at or above N never match, so they fall out as ignored frees.
    always_comb begin
        w_free_vec = '0;
        for (int i = 0; i < N; i++) begin
            w_free_vec[i] = free_valid && (free_idx == W'(i));
        end
    end

    assign w_free_eff_vec = w_free_vec & r_busy;
    assign w_free_eff     = |w_free_eff_vec;
    assign w_cnt_inc      = {{W{1'b0}}, w_hs};
    assign w_cnt_dec      = {{W{1'b0}}, w_free_eff};

    always_ff @(posedge clk) begin
        if (!resetn || clr) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            r_busy <= (r_busy | w_hs_vec) & ~w_free_eff_vec;
            r_cnt  <= r_cnt + w_cnt_inc - w_cnt_dec;
        end
    end

    assign busy_vec = r_busy;
    assign busy_cnt = r_cnt;
    assign empty    = (r_cnt == '0);
    assign full     = (r_cnt >= LIM_C);

`ifdef ATCAXI2TLUH500_IDX_ALLOC_CHECK_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_err <= 1'b0;
        end else begin
            r_err <= free_valid & ~w_free_eff & ~clr;
        end
    end

    assign err_free = r_err;

    a_popcount : assert property (
        @(posedge clk) $countones(r_busy) == int'(r_cnt)
    );

    // A free below the offered index legitimately lowers it.
    a_stall_stable : assert property (
        @(posedge clk) disable iff (!resetn)
        (alloc_valid && !alloc_ready && !clr &&
         !(w_free_eff && (free_idx < alloc_idx)))
        |=> $stable(alloc_idx)
    );
`endif

endmodule
